// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Parametrised pipeline stage with valid/ready handshake, 2-entry
//            skid buffer and synchronous flush. Updates on the falling edge.
// Revision : 1.0
// ============================================================================
module pipe_stage_skid #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_push;
    logic             w_pop;

    // All outputs decode from registered state only, so ready never depends
    // combinationally on downstream ready.
    assign out_valid = (r_state != c_EMPTY);
    assign in_ready  = (r_state != c_TWO);
    assign out_data  = r_main;
    assign occupancy = r_state;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_EMPTY;
            r_main  <= RESET_VALUE;
            r_skid  <= RESET_VALUE;
        end else if (flush) begin
            r_state <= c_EMPTY;
            r_main  <= RESET_VALUE;
            r_skid  <= RESET_VALUE;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_push) begin
                        r_state <= c_ONE;
                        r_main  <= in_data;
                    end
                end
                c_ONE: begin
                    if (w_push && !w_pop) begin
                        r_state <= c_TWO;
                        r_skid  <= in_data;
                    end else if (w_push && w_pop) begin
                        r_main  <= in_data;
                    end else if (w_pop) begin
                        r_state <= c_EMPTY;
                    end
                end
                c_TWO: begin
                    if (w_pop) begin
                        r_state <= c_ONE;
                        r_main  <= r_skid;
                    end
                end
                default: begin
                    r_state <= c_EMPTY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Brief    : Scoreboard bench for pipe_stage_skid at WIDTH=32/RV=0 and
//            WIDTH=8/RV=8'h5A, both driven by the same control stimulus.
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_skid;

    localparam logic [7:0] c_RV8 = 8'h5A;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic        in_ready8;
    logic        out_valid8;
    logic [7:0]  out_data8;
    logic [1:0]  occupancy8;

    logic [31:0] q[$];
    logic        rv_known;
    int          n_checks;
    int          n_pass;

    pipe_stage_skid #(.WIDTH(32), .RESET_VALUE(32'h0)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.WIDTH(8), .RESET_VALUE(c_RV8)) dut8 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data[7:0]),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .occupancy(occupancy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        logic [1:0] exp_occ;
        exp_occ = 2'(q.size());
        chk({tag, " occ32"},   {30'd0, occupancy},  {30'd0, exp_occ});
        chk({tag, " occ8"},    {30'd0, occupancy8}, {30'd0, exp_occ});
        chk({tag, " vld32"},   {31'd0, out_valid},  {31'd0, (q.size() != 0)});
        chk({tag, " vld8"},    {31'd0, out_valid8}, {31'd0, (q.size() != 0)});
        chk({tag, " rdy32"},   {31'd0, in_ready},   {31'd0, (q.size() < 2)});
        chk({tag, " rdy8"},    {31'd0, in_ready8},  {31'd0, (q.size() < 2)});
        if (q.size() != 0) begin
            chk({tag, " data32"}, out_data, q[0]);
            chk({tag, " data8"},  {24'd0, out_data8}, {24'd0, q[0][7:0]});
        end else if (rv_known) begin
            chk({tag, " rv32"}, out_data, 32'h0);
            chk({tag, " rv8"},  {24'd0, out_data8}, {24'd0, c_RV8});
        end
    endtask

    // One falling edge: model the handshake from the bench's own occupancy,
    // then check outputs on the following rising edge.
    task automatic tick(input string tag);
        logic push, pop;
        push = in_valid && (q.size() < 2);
        pop  = (q.size() != 0) && out_ready;
        @(negedge clk);
        if (!reset || flush) begin
            q.delete();
            rv_known = 1'b1;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                rv_known = 1'b0;
            end
            if (push) q.push_back(in_data);
        end
        @(posedge clk);
        check_outputs(tag);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rv_known = 1'b1;
        flush    = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        reset    = 1'b1;
        #1 reset = 1'b0;

        // Reset held with upstream pushing
        @(posedge clk);
        check_outputs("reset0");
        for (int i = 0; i < 3; i++) tick("reset");
        reset = 1'b1;

        // Streaming
        out_ready = 1'b1;
        in_data = 32'h11; tick("stream");
        in_data = 32'h22; tick("stream");
        in_data = 32'h33; tick("stream");
        in_valid = 1'b0;  tick("stream_drain");

        // Stall / skid
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA1; tick("skid");
        in_data = 32'hA2; tick("skid");
        in_data = 32'hA3; tick("skid_full");
        chk("skid occ2", {30'd0, occupancy}, 32'd2);
        out_ready = 1'b1;
        tick("skid_drain");
        tick("skid_drain");
        in_valid = 1'b0;
        tick("skid_drain");
        tick("skid_empty");

        // Flush at occupancy 2 with a simultaneous push
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hB1; tick("flush_fill");
        in_data = 32'hB2; tick("flush_fill");
        in_data = 32'hB3; flush = 1'b1; tick("flush");
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick("post_flush");
        tick("post_flush");

        // Asynchronous reset between edges
        in_valid = 1'b1; out_ready = 1'b0;
        in_data = 32'hC1; tick("ar_fill");
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        q.delete();
        rv_known = 1'b1;
        check_outputs("async_rst");
        @(posedge clk);
        tick("ar_hold");
        #1 reset = 1'b1;
        in_valid = 1'b1; in_data = 32'hC2;
        tick("ar_first");
        in_valid = 1'b0; out_ready = 1'b1;
        tick("ar_drain");

        // Random traffic with occasional flush; data held while stalled
        for (int i = 0; i < 400; i++) begin
            if (!(in_valid && q.size() == 2)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick("random");
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick("final");
        tick("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register for the segmented processor, replacing fixed 32-bit inter-stage latches.
- Provides a valid/ready handshake, a 2-entry skid buffer so upstream stalls do not need a combinational ready path, and a flush that squashes in-flight contents.
- Sits between any two pipeline stages, e.g. EX->MEM and MEM->WB.

Parameters:
WIDTH, 32, payload width in bits (>=1)
RESET_VALUE, 0, WIDTH-bit value loaded into both data registers on reset and on flush

Ports:
clk  input  1  clock; all state updates on the falling edge, consistent with the processor's other pipeline registers
reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk)
flush  input  1  synchronous squash, sampled on falling edge
in_valid  input  1  upstream holds valid payload
in_ready  output  1  stage can accept this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds valid payload
out_ready  input  1  downstream accepts this cycle
out_data  output  WIDTH  payload to next stage
occupancy  output  2  number of held entries, 0..2

Behaviour:
- Storage:
  - main register (drives out_data) and skid register.
  - State is one of EMPTY (0), ONE (1), TWO (2); occupancy equals the state encoding.
- Derived outputs, decoded from state only (no combinational path from in_* to out_* or from out_ready to in_ready):
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
  - out_data = main.
- Handshakes:
  - Push = in_valid & in_ready; pop = out_valid & out_ready; both sampled at the falling edge.
  - Upstream must hold in_data stable while in_valid=1 and in_ready=0.
- Transitions on the falling edge, flush=0:
  - EMPTY: push -> ONE, main<=in_data. No push -> stay.
  - ONE, push & !pop: -> TWO, skid<=in_data.
  - ONE, !push & pop: -> EMPTY, main unchanged (don't-care).
  - ONE, push & pop: stay ONE, main<=in_data.
  - ONE, neither: hold.
  - TWO, pop: -> ONE, main<=skid. Push is impossible since in_ready=0.
  - TWO, no pop: hold both registers.
- Ordering: strict FIFO; payloads leave in acceptance order, none duplicated or dropped except by flush.
- Flush (flush=1 at a falling edge):
  - Highest priority: state -> EMPTY, main and skid <= RESET_VALUE.
  - A simultaneous push is discarded even though in_ready was 1.
  - A simultaneous pop is considered completed by the downstream; the block takes no further action for it.
- Reset (reset=0, asynchronous):
  - Immediately state=EMPTY, main=skid=RESET_VALUE, out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VALUE.
  - Assertion mid-transfer aborts it; held data is lost.
  - The first falling edge after release (reset=1) operates normally.
- Width: payload is passed bit-exact; no arithmetic is performed.

Test Plan:
1. Reset: hold reset=0 with in_valid=1, in_data=0xDEADBEEF, toggle 3 clocks -> out_valid=0, out_data=0, in_ready=1, occupancy=0 throughout.
2. Streaming: out_ready=1, push 0x11,0x22,0x33 on consecutive falling edges -> out_data shows 0x11,0x22,0x33 one edge after each push, occupancy stays 1, in_ready stays 1.
3. Stall/skid: out_ready=0, push 0xA1 then 0xA2 -> occupancy=2, in_ready=0; a 0xA3 held on in_valid is not accepted. Raise out_ready -> outputs 0xA1, 0xA2, 0xA3 in order with no loss.
4. Flush: at occupancy 2 (0xB1,0xB2), assert flush with in_valid=1, in_data=0xB3 -> next edge occupancy=0, out_valid=0, out_data=RESET_VALUE; 0xB3 never appears at the output.
5. Async reset mid-operation: occupancy=1 with main=0xC1; drop reset between clock edges -> out_valid falls before the next edge; after release a push of 0xC2 appears as the first output.
6. Parameter sweep: WIDTH=8, RESET_VALUE=8'h5A -> after reset and after a flush, out_data=0x5A; scenario 3 passes with 8-bit payloads.
